// File: rtl/approx_error_monitor.sv
// approx_error_monitor
// Error-characterization engine for 8-bit approximate adders. It accepts
// (A, B, Cin, S_approx) samples over a valid/ready handshake and recomputes
// the exact sum. Over a programmed run of N samples it accumulates the
// error count, the maximum error distance and the summed error distance.
// Optional feature macro: AEM_BIAS_EN adds the signed err_bias accumulator.
module approx_error_monitor (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_samples,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic        Cin,
  input  logic [8:0]  S_approx,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] err_count,
  output logic [8:0]  max_ed,
  output logic [24:0] sum_ed,
  output logic        busy,
  output logic        done
`ifdef AEM_BIAS_EN
  ,
  output logic signed [25:0] err_bias
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  // Run control: latched sample count and accepted-sample counter
  logic [15:0] n_reg;
  logic [15:0] acc_reg;

  // Stage 1: registered sample
  logic        s1_valid_reg;
  logic [7:0]  s1_a_reg;
  logic [7:0]  s1_b_reg;
  logic        s1_cin_reg;
  logic [8:0]  s1_s_reg;

  // Stage 1 combinational results
  logic [8:0]  exact;
  logic [9:0]  diff;
  logic [9:0]  diff_abs;
  logic [8:0]  ed;

  // Stage 2 inputs: registered error distance
  logic        ed_valid_reg;
  logic [8:0]  ed_reg;

  // Accumulators
  logic [15:0] err_count_reg;
  logic [8:0]  max_ed_reg;
  logic [24:0] sum_ed_reg;

`ifdef AEM_BIAS_EN
  logic [9:0]         diff_reg;
  logic signed [25:0] err_bias_reg;
`endif

  logic        launch;
  logic        xfer;
  logic        last_xfer;

  // A run can only be launched from a quiescent state; start elsewhere is ignored
  assign launch    = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign in_ready  = (state_reg == ST_RUN) && (acc_reg < n_reg);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (({1'b0, acc_reg} + 17'd1) == {1'b0, n_reg});

  // Next-state and status decode
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (num_samples == 16'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_xfer) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // The sample in the ED register is folded in on this same edge,
        // so only stage 1 has to be empty before the run is complete.
        if (!s1_valid_reg) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = (num_samples == 16'd0) ? ST_DONE : ST_RUN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register and run bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      n_reg     <= 16'd0;
      acc_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        n_reg   <= num_samples;
        acc_reg <= 16'd0;
      end else if (xfer) begin
        acc_reg <= acc_reg + 16'd1;
      end
    end
  end

  // Stage 1 capture of each transferred sample
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= 8'd0;
      s1_b_reg     <= 8'd0;
      s1_cin_reg   <= 1'b0;
      s1_s_reg     <= 9'd0;
    end else begin
      s1_valid_reg <= xfer;
      if (xfer) begin
        s1_a_reg   <= A;
        s1_b_reg   <= B;
        s1_cin_reg <= Cin;
        s1_s_reg   <= S_approx;
      end
    end
  end

  // Exact sum and signed difference; |diff| never exceeds 511 so it fits 9 bits
  always_comb begin
    exact    = {1'b0, s1_a_reg} + {1'b0, s1_b_reg} + {8'd0, s1_cin_reg};
    diff     = {1'b0, s1_s_reg} - {1'b0, exact};
    diff_abs = diff[9] ? (10'd0 - diff) : diff;
    ed       = diff_abs[8:0];
  end

  // Stage 1 output register: error distance plus its valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      ed_valid_reg <= 1'b0;
      ed_reg       <= 9'd0;
    end else begin
      ed_valid_reg <= s1_valid_reg;
      ed_reg       <= ed;
    end
  end

`ifdef AEM_BIAS_EN
  // Signed difference travels alongside the error distance
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_reg <= 10'd0;
    end else begin
      diff_reg <= diff;
    end
  end
`endif

  // Stage 2 accumulation; cleared when a new run launches
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      err_count_reg <= 16'd0;
      max_ed_reg    <= 9'd0;
      sum_ed_reg    <= 25'd0;
    end else if (ed_valid_reg) begin
      err_count_reg <= err_count_reg + {15'd0, (ed_reg != 9'd0)};
      if (ed_reg > max_ed_reg) begin
        max_ed_reg <= ed_reg;
      end
      sum_ed_reg    <= sum_ed_reg + {16'd0, ed_reg};
    end
  end

`ifdef AEM_BIAS_EN
  // Signed bias accumulation of (S_approx - exact)
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      err_bias_reg <= 26'sd0;
    end else if (ed_valid_reg) begin
      err_bias_reg <= err_bias_reg + $signed({{16{diff_reg[9]}}, diff_reg});
    end
  end

  assign err_bias = err_bias_reg;
`endif

  assign err_count = err_count_reg;
  assign max_ed    = max_ed_reg;
  assign sum_ed    = sum_ed_reg;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Testbench for approx_error_monitor: directed scenarios plus randomized runs,
// checked every cycle against a behavioural model built on a queue of
// pending per-sample contributions.
module tb_approx_error_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        Cin;
  logic [8:0]  S_approx;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] err_count;
  logic [8:0]  max_ed;
  logic [24:0] sum_ed;
  logic        busy;
  logic        done;
`ifdef AEM_BIAS_EN
  logic signed [25:0] err_bias;
`endif

  always #5 clk = ~clk;

  approx_error_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .A           (A),
    .B           (B),
    .Cin         (Cin),
    .S_approx    (S_approx),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .err_count   (err_count),
    .max_ed      (max_ed),
    .sum_ed      (sum_ed),
    .busy        (busy),
    .done        (done)
`ifdef AEM_BIAS_EN
    ,
    .err_bias    (err_bias)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 accepting, 2 finishing, 3 done
  int     phase = 0;
  int     m_n = 0;
  int     m_acc = 0;
  int     done_edge = 0;
  int     ecount = 0;
  longint m_cnt = 0;
  longint m_max = 0;
  longint m_sum = 0;
  longint m_bias = 0;
  int     q_when[$];
  int     q_ed[$];
  int     q_diff[$];

  // Directed stimulus: {A, B, Cin, S_approx} and valid pattern
  logic [25:0] sq[$];
  bit          vq[$];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic model_clear();
    m_cnt  = 0;
    m_max  = 0;
    m_sum  = 0;
    m_bias = 0;
    q_when.delete();
    q_ed.delete();
    q_diff.delete();
  endtask

  // One clock: update model from the driven inputs, advance, then compare
  task automatic tick();
    int want_sum;
    int d;
    int e;
    want_sum = int'(A) + int'(B) + int'(Cin);
    if (rst) begin
      phase = 0;
      m_n   = 0;
      m_acc = 0;
      model_clear();
    end else if (start && (phase == 0 || phase == 3)) begin
      model_clear();
      m_n   = int'(num_samples);
      m_acc = 0;
      phase = (m_n == 0) ? 3 : 1;
    end else if (phase == 1 && in_valid && m_acc < m_n) begin
      d = int'(S_approx) - want_sum;
      e = (d < 0) ? -d : d;
      q_when.push_back(ecount + 3);
      q_ed.push_back(e);
      q_diff.push_back(d);
      m_acc++;
      $display("xfer %0d/%0d A=%02h B=%02h Cin=%0d S=%03h exact=%0d ed=%0d",
               m_acc, m_n, A, B, Cin, S_approx, want_sum, e);
      if (m_acc == m_n) begin
        phase     = 2;
        done_edge = ecount + 3;
      end
    end
    @(posedge clk);
    ecount++;
    #1;
    while (q_when.size() > 0 && q_when[0] <= ecount) begin
      e = q_ed.pop_front();
      d = q_diff.pop_front();
      void'(q_when.pop_front());
      if (e != 0) m_cnt++;
      if (e > m_max) m_max = e;
      m_sum  += e;
      m_bias += d;
    end
    if (phase == 2 && ecount >= done_edge) phase = 3;
    check("in_ready", 64'(in_ready), 64'(phase == 1 && m_acc < m_n));
    check("busy", 64'(busy), 64'(phase == 1 || phase == 2));
    check("done", 64'(done), 64'(phase == 3));
    check("err_count", 64'(err_count), m_cnt);
    check("max_ed", 64'(max_ed), m_max);
    check("sum_ed", 64'(sum_ed), m_sum);
`ifdef AEM_BIAS_EN
    check("err_bias", 64'(err_bias), m_bias);
`endif
  endtask

  task automatic rand_sample();
    int ex;
    int off;
    A   = 8'($urandom);
    B   = 8'($urandom);
    Cin = 1'($urandom);
    ex  = int'(A) + int'(B) + int'(Cin);
    case ($urandom_range(3))
      0: S_approx = 9'(ex);
      1: begin
        off = int'($urandom_range(8)) - 4;
        if (ex + off < 0 || ex + off > 511) off = 0;
        S_approx = 9'(ex + off);
      end
      2: S_approx = 9'($urandom);
      default: S_approx = 9'(ex) ^ 9'(1 << $urandom_range(3));
    endcase
  endtask

  // Launch a run of n samples and stream until done or the cycle budget ends
  task automatic run(input int n, input int vprob, input bit noisy);
    num_samples = 16'(n);
    start       = 1'b1;
    in_valid    = 1'b0;
    rand_sample();
    tick();
    start = 1'b0;
    for (int c = 0; c < n * 30 + 40 && done !== 1'b1; c++) begin
      bit v;
      if (vq.size() > 0) v = vq.pop_front();
      else v = ($urandom_range(99) < vprob);
      if (v && sq.size() > 0) {A, B, Cin, S_approx} = sq.pop_front();
      else rand_sample();
      in_valid = v;
      if (noisy) begin
        start       = ($urandom_range(9) == 0);
        num_samples = 16'($urandom);
      end
      tick();
      start = 1'b0;
    end
    in_valid    = 1'b0;
    start       = 1'b0;
    num_samples = 16'd0;
    check("run_done", 64'(done), 64'd1);
  endtask

  // Idle cycles with junk samples offered; nothing may be accepted
  task automatic idle_noise(input int k);
    for (int i = 0; i < k; i++) begin
      in_valid = 1'b1;
      rand_sample();
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_samples = 16'd0;
    A           = 8'd0;
    B           = 8'd0;
    Cin         = 1'b0;
    S_approx    = 9'd0;
    in_valid    = 1'b0;

    // Reset held two cycles, then valid without start
    tick();
    tick();
    rst = 1'b0;
    idle_noise(4);

    // Single erroneous sample: exact 4, approx 6
    sq.push_back({8'h03, 8'h01, 1'b0, 9'h006});
    vq.push_back(1'b1);
    run(1, 100, 1'b0);
    check("single_err_count", 64'(err_count), 64'd1);
    check("single_max_ed", 64'(max_ed), 64'd2);
    check("single_sum_ed", 64'(sum_ed), 64'd2);
`ifdef AEM_BIAS_EN
    check("single_bias", 64'(err_bias), 64'sd2);
`endif

    // Four exact samples, including the 0x1FF corner
    sq.push_back({8'hFF, 8'hFF, 1'b1, 9'h1FF});
    sq.push_back({8'h10, 8'h20, 1'b0, 9'h030});
    sq.push_back({8'h00, 8'h00, 1'b0, 9'h000});
    sq.push_back({8'h80, 8'h7F, 1'b1, 9'h100});
    for (int i = 0; i < 4; i++) vq.push_back(1'b1);
    run(4, 100, 1'b0);
    check("exact_err_count", 64'(err_count), 64'd0);
    check("exact_max_ed", 64'(max_ed), 64'd0);
    check("exact_sum_ed", 64'(sum_ed), 64'd0);

    // Backpressure: EDs 1, 3, 0 with signs +1, -3; valid pattern 1-0-1-1
    sq.push_back({8'h05, 8'h05, 1'b0, 9'd11});
    sq.push_back({8'd20, 8'd0, 1'b1, 9'd18});
    sq.push_back({8'h01, 8'h02, 1'b0, 9'd3});
    vq.push_back(1'b1);
    vq.push_back(1'b0);
    vq.push_back(1'b1);
    vq.push_back(1'b1);
    vq.push_back(1'b1);
    run(3, 100, 1'b0);
    check("bp_err_count", 64'(err_count), 64'd2);
    check("bp_max_ed", 64'(max_ed), 64'd3);
    check("bp_sum_ed", 64'(sum_ed), 64'd4);
`ifdef AEM_BIAS_EN
    check("bp_bias", 64'(err_bias), -64'sd2);
`endif

    // Zero-length run, then restart with N=2
    run(0, 100, 1'b0);
    check("zero_err_count", 64'(err_count), 64'd0);
    check("zero_sum_ed", 64'(sum_ed), 64'd0);
    run(2, 70, 1'b0);

    // Reset mid-run after five transfers
    num_samples = 16'd10;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      rand_sample();
      tick();
    end
    rst = 1'b1;
    start = 1'b1;
    num_samples = 16'd3;
    tick();
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    idle_noise(2);
    run(1, 100, 1'b0);

    // Randomized runs, some with ignored start pulses mid-run
    for (int r = 0; r < 12; r++) begin
      run(int'($urandom_range(40, 1)), int'($urandom_range(100, 30)), r[0]);
      idle_noise(int'($urandom_range(3)));
    end
    run(200, 100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_error_monitor.md
# approx_error_monitor

Sequential error-characterization engine for the 8-bit approximate ripple-carry adders. It consumes a stream of operand/result samples (A, B, Cin, approximate 9-bit sum) over a valid/ready handshake and recomputes the exact sum internally. Over a programmed number of samples it accumulates error count, maximum error distance and summed error distance. It sits beside an approximate adder under test, in a sweep or random-stimulus harness, and reports metrics when the run completes.

## Interface
- No parameters; all widths fixed.
- `clk  input  1` — single clock, rising edge.
- `rst  input  1` — synchronous, active-high reset.
- `start  input  1` — pulse; begins a run of `num_samples` samples.
- `num_samples  input  16` — sample count, captured when `start` is accepted.
- `A  input  8` — operand A of the sample.
- `B  input  8` — operand B of the sample.
- `Cin  input  1` — carry-in of the sample.
- `S_approx  input  9` — approximate adder result, where bit 8 is the carry-out position.
- `in_valid  input  1` — sample present.
- `in_ready  output  1` — monitor accepts a sample this cycle.
- `err_count  output  16` — number of samples with `S_approx` different from the exact sum.
- `max_ed  output  9` — maximum error distance seen.
- `sum_ed  output  25` — sum of error distances.
- `busy  output  1` — high in RUN or DRAIN.
- `done  output  1` — high in DONE.
- `err_bias  output  26 signed` — present only with `AEM_BIAS_EN`; sum of (S_approx − exact).

## Operation
- **Exact sum:** `exact = A + B + Cin`, 9-bit unsigned, range 0..511.
- **Error distance:** `ED = |S_approx − exact|`, 9-bit unsigned.
  - A sample is erroneous iff `ED != 0`.
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE / DONE, `start`=1:**
  - clear all accumulators;
  - latch `num_samples` into N;
  - reset the accepted-sample counter;
  - go to RUN, or directly to DONE if N=0 (accumulators stay zero).
- **RUN:**
  - `in_ready` = 1 while accepted < N.
  - Transfer occurs when `in_valid & in_ready`.
  - On the transfer that makes accepted == N, go to DRAIN. `in_ready` is 0 from the next cycle.
- **DRAIN:** wait until the pipeline holds no valid sample, then go to DONE.
- **DONE:**
  - accumulators hold;
  - `done` = 1 until the next `start` or `rst`.
- **`start` in RUN or DRAIN:** ignored.
- **`in_valid` outside RUN:** ignored; nothing accumulates.
- **Pipeline:**
  - Stage 1 registers the sample and computes `exact` and `ED`, then registers `ED` and its valid bit.
  - Stage 2 updates the accumulators:
    - `err_count += (ED!=0)`;
    - `max_ed = max(max_ed, ED)`;
    - `sum_ed += ED`.
- **Accumulator widths and saturation:**
  - `sum_ed` worst case is 511×65535 < 2^25, so no overflow is possible.
  - `err_count` is bounded by N ≤ 65535.
  - No saturation logic is required.

## Timing
- **Reset values (after `rst`):**
  - state IDLE;
  - `in_ready` = 0, `busy` = 0, `done` = 0;
  - `err_count`, `max_ed`, `sum_ed` and `err_bias` all 0;
  - pipeline valids 0.
- **Entering RUN:** `start` sampled at edge t puts the monitor in RUN from t+1. `in_ready` is combinational from the state and counter, so it is 1 in cycle t+1.
- **Accumulator latency:** a sample transferred at edge t is reflected in the accumulator outputs after edge t+2.
- **Done latency:** with the last transfer at edge t, `done` = 1 from cycle t+3. `busy` falls in the same cycle.
- **Back-to-back transfers:** a transfer every cycle is sustained, for a throughput of 1 sample/cycle.
- **`rst` mid-run:** the run is aborted, the pipeline is flushed and the reset values above apply on the next cycle.
- **`rst` and `start` in the same cycle:** `rst` wins.

## Configuration
- **`AEM_BIAS_EN` defined:**
  - adds output `err_bias`, a 26-bit two's-complement value;
  - stage 2 accumulates the signed 10-bit difference (S_approx − exact);
  - it is cleared on `start` and on `rst`.
  - This measures systematic bias; the lower-bits approximate FAs tend to produce a signed offset.
- **`AEM_BIAS_EN` not defined:**
  - port and logic are absent;
  - all other behaviour is identical.

## Test plan
- **Reset:** hold `rst` 2 cycles → all outputs 0 and state IDLE; `in_valid`=1 with no `start` → `in_ready` stays 0 and the counters stay 0.
- **Single sample:** N=1, sample A=0x03, B=0x01, Cin=0, S_approx=0x006 (exact 4) → `err_count`=1, `max_ed`=2, `sum_ed`=2, `done` 3 cycles after the transfer, `err_bias`=+2.
- **Exact samples:** N=4, four samples with S_approx == exact (e.g. 0xFF+0xFF+1 → 0x1FF) → `err_count`=0, `max_ed`=0, `sum_ed`=0, `done`=1.
- **Streaming with backpressure:** N=3, samples with ED 1, 3, 0, `in_valid` toggled 1-0-1-1 → exactly 3 transfers counted, `in_ready`=0 after the third transfer, `err_count`=2, `max_ed`=3, `sum_ed`=4, and with the macro defined `err_bias` = −2 when the ED=3 sample has S_approx < exact (signs +1, −3).
- **Zero-length and restart:** `start` with N=0 → `done`=1 next cycle with all accumulators 0; `start` again with N=2 → the previous results are cleared and a new run executes.
- **Reset mid-run:** N=10, assert `rst` after 5 transfers → next cycle IDLE with all outputs 0; a following `start` with N=1 completes normally.
